urv_dm_responder: RTL and testbench

URV_DM_RESPONDER -- requirements
Module: urv_dm_responder

---
 rtl/urv_dm_responder.sv | 167 ++++++++++++++++
 tb/tb_urv_dm_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_dm_responder.sv
// Data-memory responder for the uRV core: serves a local single-cycle RAM window
// directly and forwards every other address to a pipelined Wishbone master.
module urv_dm_responder #(
    parameter int unsigned g_ram_aw     = 14,
    parameter int unsigned g_wb_timeout = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic [31:0]         dm_addr_i,
    input  logic [31:0]         dm_data_s_i,
    input  logic [3:0]          dm_data_select_i,
    input  logic                dm_load_i,
    input  logic                dm_store_i,
    output logic                dm_ready_o,
    output logic [31:0]         dm_data_l_o,
    output logic                dm_load_done_o,
    output logic                dm_store_done_o,
    output logic                dm_bus_error_o,

    output logic [g_ram_aw-1:0] ram_addr_o,
    output logic [31:0]         ram_data_o,
    output logic [3:0]          ram_bwe_o,
    input  logic [31:0]         ram_data_i,

    output logic [31:0]         wb_adr_o,
    output logic [31:0]         wb_dat_o,
    output logic [3:0]          wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [31:0]         wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic                wb_stall_i
);

    typedef enum logic [1:0] {
        IDLE,
        WB_REQ,
        WB_WAIT
    } state_t;

    // Last WB_WAIT cycle before giving up: timer counts 0 .. g_wb_timeout-1.
    localparam logic [7:0] c_timer_last = 8'(g_wb_timeout - 1);

    state_t      state, state_nxt;
    logic [7:0]  timer;
    logic        req_any, ram_hit, accept, acc_ram, acc_wb;
    logic        wb_done, wb_fail;

    logic [31:0] adr_q, dat_q, data_q;
    logic [3:0]  sel_q;
    logic        we_q, ram_load_q;
    logic        load_done_q, store_done_q, bus_err_q;

    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^dm_addr_i[1:0];

    assign req_any = dm_load_i | dm_store_i;
    assign ram_hit = (dm_addr_i[31:g_ram_aw+2] == '0);
    assign accept  = dm_ready_o & req_any;
    assign acc_ram = accept & ram_hit;
    assign acc_wb  = accept & ~ram_hit;

    assign ram_addr_o = dm_addr_i[g_ram_aw+1:2];
    assign ram_data_o = dm_data_s_i;
    assign ram_bwe_o  = (acc_ram & dm_store_i) ? dm_data_select_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wb_done   = 1'b0;
        wb_fail   = 1'b0;
        unique case (state)
            IDLE: begin
                if (acc_wb)
                    state_nxt = WB_REQ;
            end
            WB_REQ: begin
                if (!wb_stall_i) begin
                    if (wb_ack_i | wb_err_i) begin
                        state_nxt = IDLE;
                        wb_done   = 1'b1;
                        wb_fail   = wb_err_i;
                    end else begin
                        state_nxt = WB_WAIT;
                    end
                end
            end
            WB_WAIT: begin
                if (wb_ack_i | wb_err_i) begin
                    state_nxt = IDLE;
                    wb_done   = 1'b1;
                    wb_fail   = wb_err_i;
                end else if (timer == c_timer_last) begin
                    state_nxt = IDLE;
                    wb_done   = 1'b1;
                    wb_fail   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wb_cyc_o   = 1'b0;
        wb_stb_o   = 1'b0;
        dm_ready_o = 1'b0;
        unique case (state)
            IDLE:    dm_ready_o = ~rst_i;
            WB_REQ:  begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
            end
            WB_WAIT: wb_cyc_o = 1'b1;
            default: dm_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer        <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            data_q       <= '0;
            ram_load_q   <= 1'b0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            timer        <= (state == WB_WAIT) ? timer + 8'd1 : '0;
            ram_load_q   <= acc_ram & ~dm_store_i;
            load_done_q  <= (acc_ram & ~dm_store_i) | (wb_done & ~we_q);
            store_done_q <= (acc_ram & dm_store_i) | (wb_done & we_q);
            bus_err_q    <= wb_done & wb_fail;
            if (acc_wb) begin
                adr_q <= {dm_addr_i[31:2], 2'b00};
                dat_q <= dm_data_s_i;
                sel_q <= dm_data_select_i;
                we_q  <= dm_store_i;
            end
            if (wb_done)
                data_q <= (wb_fail | we_q) ? '0 : wb_dat_i;
        end
    end

    // RAM read data is already registered by the RAM itself, so it is passed through.
    assign dm_data_l_o     = ram_load_q ? ram_data_i : data_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_bus_error_o  = bus_err_q;

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q & wb_cyc_o;

endmodule

// File: tb/tb_urv_dm_responder.sv
// Randomized self-checking bench for urv_dm_responder: transaction-level model of
// RAM contents and Wishbone completion timing derived from the request rules.
module tb_urv_dm_responder;

    localparam int unsigned AW  = 8;
    localparam int unsigned TMO = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [31:0]   dm_addr_i, dm_data_s_i;
    logic [3:0]    dm_data_select_i;
    logic          dm_load_i, dm_store_i;
    logic          dm_ready_o;
    logic [31:0]   dm_data_l_o;
    logic          dm_load_done_o, dm_store_done_o, dm_bus_error_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_data_o;
    logic [3:0]    ram_bwe_o;
    logic [31:0]   ram_data_i;
    logic [31:0]   wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o;
    logic          wb_ack_i, wb_err_i, wb_stall_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram_mem [256];
    logic [31:0] ref_mem [256];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          kind;   // 0 load, 1 store, 2 load+store
    } req_t;
    req_t reqs[$];

    urv_dm_responder #(.g_ram_aw(AW), .g_wb_timeout(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
        .dm_data_select_i(dm_data_select_i),
        .dm_load_i(dm_load_i), .dm_store_i(dm_store_i),
        .dm_ready_o(dm_ready_o), .dm_data_l_o(dm_data_l_o),
        .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
        .dm_bus_error_o(dm_bus_error_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_bwe_o(ram_bwe_o), .ram_data_i(ram_data_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_stall_i(wb_stall_i)
    );

    always #5 clk = ~clk;

    // Byte-writable RAM with registered read.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_bwe_o[b])
                ram_mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
        ram_data_i <= ram_mem[ram_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        dm_load_i        = 1'b0;
        dm_store_i       = 1'b0;
        dm_addr_i        = '0;
        dm_data_s_i      = '0;
        dm_data_select_i = '0;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int kind);
        dm_addr_i        = a;
        dm_data_s_i      = d;
        dm_data_select_i = s;
        dm_load_i        = (kind != 1);
        dm_store_i       = (kind != 0);
    endtask

    // Back-to-back RAM requests, one per cycle; each completes the following cycle.
    task automatic run_ram();
        bit          pl = 1'b0, ps = 1'b0;
        logic [31:0] pd = '0;
        int          n = reqs.size();
        int          w;
        req_t        r;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i < n) begin
                r = reqs[i];
                drive_req(r.addr, r.data, r.sel, r.kind);
            end else begin
                idle_inputs();
            end
            #1;
            check("ram_ready", dm_ready_o, 1'b1);
            if (i < n) begin
                w = int'(r.addr[AW+1:2]);
                check("ram_addr", ram_addr_o, r.addr[AW+1:2]);
                check("ram_bwe", ram_bwe_o, (r.kind != 0) ? r.sel : 4'h0);
                if (r.kind != 0) check("ram_wdata", ram_data_o, r.data);
            end
            check("ram_ld_done", dm_load_done_o, pl);
            check("ram_st_done", dm_store_done_o, ps);
            check("ram_berr", dm_bus_error_o, 1'b0);
            if (pl) check("ram_ld_data", dm_data_l_o, pd);
            pl = 1'b0;
            ps = 1'b0;
            if (i < n) begin
                if (r.kind == 0) begin
                    pl = 1'b1;
                    pd = ref_mem[w];
                end else begin
                    ps = 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (r.sel[b]) ref_mem[w][8*b +: 8] = r.data[8*b +: 8];
                end
            end
        end
        reqs.delete();
    endtask

    // One Wishbone transaction. resp: 0 ack, 1 err, 2 none, 3 ack+err.
    // delay = WB_WAIT cycle (1-based) carrying the response, 0 = during the last stb cycle.
    task automatic wb_txn(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input int kind, input int stalls,
                          input int delay, input int resp, input logic [31:0] rdata,
                          input bit ghost);
        bit          timed_out = (resp == 2) || (delay > int'(TMO));
        bit          fail      = timed_out || resp == 1 || resp == 3;
        int          eff       = timed_out ? int'(TMO) : delay;
        int          done_c    = 2 + stalls + eff;
        int          resp_c    = 1 + stalls + delay;
        bit          busy;
        logic [31:0] exp_data  = (fail || kind != 0) ? 32'h0 : rdata;
        for (int c = 0; c <= done_c + 1; c++) begin
            @(negedge clk);
            if (c == 0)
                drive_req(addr, data, sel, kind);
            else if (ghost && c == 2 && done_c >= 3)
                drive_req(32'h0000_0020, $urandom, 4'hF, 2);
            else
                idle_inputs();
            wb_stall_i = (c >= 1 && c <= stalls);
            wb_ack_i   = !timed_out && c == resp_c && resp != 1;
            wb_err_i   = !timed_out && c == resp_c && (resp == 1 || resp == 3);
            wb_dat_i   = (c == resp_c) ? rdata : $urandom;
            #1;
            busy = (c >= 1 && c < done_c);
            check("wb_cyc", wb_cyc_o, busy);
            check("wb_stb", wb_stb_o, c >= 1 && c <= 1 + stalls);
            check("wb_ready", dm_ready_o, !busy);
            check("wb_bwe", ram_bwe_o, 4'h0);
            if (busy) begin
                check("wb_adr", wb_adr_o, {addr[31:2], 2'b00});
                check("wb_we", wb_we_o, kind != 0);
            end
            if (c == 1) begin
                check("wb_sel", wb_sel_o, sel);
                check("wb_dat", wb_dat_o, data);
            end
            check("wb_ld_done", dm_load_done_o, c == done_c && kind == 0);
            check("wb_st_done", dm_store_done_o, c == done_c && kind != 0);
            check("wb_berr", dm_bus_error_o, c == done_c && fail);
            if (c == done_c && kind == 0) check("wb_ld_data", dm_data_l_o, exp_data);
        end
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
    endtask

    function automatic logic [31:0] rand_wb_addr();
        logic [31:0] a = $urandom;
        if ($urandom_range(0, 3) == 0) a = 32'h0000_0400 + 32'($urandom_range(0, 3));
        if (a[31:AW+2] == '0) a[31] = 1'b1;
        return a;
    endfunction

    function automatic req_t rand_ram_req();
        req_t r;
        int   w = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 15));
        r.addr = 32'(w) * 4 + 32'($urandom_range(0, 3));
        r.data = $urandom;
        r.sel  = 4'($urandom_range(0, 15));
        r.kind = int'($urandom_range(0, 2));
        return r;
    endfunction

    initial begin
        req_t r;
        int   st;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_dat_i   = '0;
        rst_i      = 1'b1;
        drive_req(32'h0, 32'hFFFF_FFFF, 4'hF, 1);
        repeat (3) @(negedge clk);
        #1;
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_stb", wb_stb_o, 1'b0);
        check("rst_we", wb_we_o, 1'b0);
        check("rst_bwe", ram_bwe_o, 4'h0);
        check("rst_ld_done", dm_load_done_o, 1'b0);
        check("rst_st_done", dm_store_done_o, 1'b0);
        check("rst_berr", dm_bus_error_o, 1'b0);
        check("rst_data", dm_data_l_o, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        idle_inputs();
        #1;
        check("rel_ready", dm_ready_o, 1'b1);

        // Store then load back-to-back to word 0x10, plus store-wins and last RAM word.
        reqs.push_back('{32'h0000_0010, 32'hA5A5_A5A5, 4'b0011, 1});
        reqs.push_back('{32'h0000_0010, 32'h0, 4'hF, 0});
        reqs.push_back('{32'h0000_0020, 32'h1122_3344, 4'hF, 2});
        reqs.push_back('{32'h0000_0020, 32'h0, 4'hF, 0});
        reqs.push_back('{32'h0000_03FC, 32'hCAFE_F00D, 4'b1100, 1});
        reqs.push_back('{32'h0000_03FC, 32'h0, 4'h0, 0});
        run_ram();

        wb_txn(32'h8000_0004, 32'h0, 4'hF, 0, 2, 3, 0, 32'h1234_5678, 1'b1);
        wb_txn(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 1, 0, 1, 1, 32'h5555_5555, 1'b0);
        wb_txn(32'h9000_0000, 32'h0, 4'hF, 0, 1, 0, 2, 32'h7777_7777, 1'b1);
        wb_txn(32'h0000_0403, 32'h0, 4'h1, 0, 0, 0, 0, 32'hABCD_0123, 1'b0);
        wb_txn(32'h8000_0008, 32'h0, 4'hF, 0, 0, 2, 3, 32'h9999_9999, 1'b0);
        wb_txn(32'h8000_000C, 32'h0, 4'hF, 0, 0, TMO, 0, 32'h0F0F_0F0F, 1'b0);
        wb_txn(32'h8000_0010, 32'h0246_8ACE, 4'h6, 2, 1, TMO + 1, 0, 32'h0, 1'b1);

        // Reset while waiting for a response; the late ack must be ignored.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) drive_req(32'h8000_0010, 32'h0, 4'hF, 0);
            else idle_inputs();
            rst_i    = (c == 3);
            wb_ack_i = (c == 4);
            wb_dat_i = 32'h3333_3333;
            #1;
            if (c == 3) check("rw_cyc_before", wb_cyc_o, 1'b1);
            if (c >= 4) begin
                check("rw_cyc", wb_cyc_o, 1'b0);
                check("rw_ready", dm_ready_o, 1'b1);
                check("rw_ld_done", dm_load_done_o, 1'b0);
                check("rw_berr", dm_bus_error_o, 1'b0);
            end
        end
        wb_ack_i = 1'b0;

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                st = int'($urandom_range(1, 6));
                for (int k = 0; k < st; k++) begin
                    r = rand_ram_req();
                    reqs.push_back(r);
                end
                run_ram();
            end else begin
                wb_txn(rand_wb_addr(), $urandom, 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, TMO + 2)), int'($urandom_range(0, 3)),
                       $urandom, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
